imem_loader: RTL
================

# imem_loader

Boot-time instruction-memory writer for the single-cycle RISC-V core. It accepts a byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit words. It writes each word into instruction memory at consecutive word-aligned byte addresses starting at 0. It holds the processor in reset until the final word is written, then releases it so execution starts at PC = 0.

## Interface

Clocking and reset (already decided): one clock, `clk`; reset `rst` is synchronous and active-high.

Parameters:
- `DEPTH`, default 64: instruction-memory capacity in 32-bit words.
- `CNT_W`, default $clog2(DEPTH+1): width of the word counter.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_valid` in 1: byte available.
- `s_data` in 8: byte value.
- `s_last` in 1: qualifies the final byte of the image; sampled with the byte.
- `s_ready` out 1: loader can accept a byte.
- `mem_we` out 1: instruction-memory write strobe.
- `mem_addr` out 32: byte address, always word-aligned.
- `mem_wdata` out 32: packed word.
- `cpu_rst_n` out 1: processor reset, active-low.
- `done` out 1: image loaded; sticky.
- `err` out 1: load aborted; sticky.
- `words_loaded` out CNT_W: number of words written.

## Operation

States:
- **LOAD**
  - `s_ready` = 1.
  - Each accepted byte (`s_valid` && `s_ready`) is stored into lane `byte_cnt`, bits [8k+7:8k], and `byte_cnt` increments.
  - If `s_last` is accepted with `byte_cnt` ≠ 3, go to ERR. The partial word is not written.
  - On acceptance with `byte_cnt` = 3, go to WRITE and latch `last_q` = `s_last`.
- **WRITE** (one cycle)
  - `mem_we` = 1, `mem_addr` = `word_addr` << 2, `mem_wdata` = packed word, `s_ready` = 0.
  - On exit, `word_addr` and `words_loaded` increment and `byte_cnt` = 0.
  - If `last_q`, go to DONE.
  - Else if `word_addr` = DEPTH-1, go to ERR (overflow).
  - Else go to LOAD.
- **DONE**
  - `done` = 1, `cpu_rst_n` = 1, `s_ready` = 0.
  - Held until `rst`.
- **ERR**
  - `err` = 1, `cpu_rst_n` = 0, `s_ready` = 0.
  - Held until `rst`.

Rules:
- `cpu_rst_n` = 0 in every state except DONE.
- A byte presented while `s_ready` = 0 is not consumed. The source must hold `s_data` and `s_last` stable until accepted.
- `s_last` is ignored unless `s_valid` is high.
- An empty image is not possible; at least one full word is required to reach DONE.

## Timing

Reset values, state LOAD:
- `s_ready` = 1
- `mem_we` = 0
- `mem_addr` = 0
- `mem_wdata` = 0
- `cpu_rst_n` = 0
- `done` = 0
- `err` = 0
- `words_loaded` = 0
- Internal counters = 0

Cycle behaviour:
- All outputs decode registered state and registers only; there is no combinational path from `s_*` inputs to outputs.
- Latency: 4th byte accepted at edge N → `mem_we` high during cycle N..N+1 → memory write at edge N+1.
- `done` and `cpu_rst_n` rise after edge N+1 when `last_q` is set.
- Peak throughput is 4 bytes per 5 cycles.

Boundary conditions:
- Reset mid-load (any state): returns to LOAD with counters at 0. Already-written memory words are not cleared. `cpu_rst_n` drops or stays low in the same cycle the reset is sampled.
- Reset during WRITE: the write in that cycle still occurs, because the strobe is registered from the prior state.
- Counters: `word_addr` never exceeds DEPTH-1. The overflow rule fires before any wrap.

## Structure

Shared package `riscv_pkg`:
- `loader_state_t` enum: LOAD, WRITE, DONE, ERR.
- `BYTES_PER_WORD` = 4.
- `IMEM_BASE` = 32'h0.

Sub-module `imem_word_packer` is natural: a byte-lane shift register plus 2-bit lane counter, with inputs `push` and `clear`, and outputs `word` and `full`. The FSM and address counter stay in `imem_loader`.

## Test plan

- **Single word:** bytes 13, 03, B0, 00 with `s_last` on 00 → exactly one `mem_we` pulse with `mem_addr` = 0 and `mem_wdata` = 00B00313; next cycle `done` = 1, `cpu_rst_n` = 1, `words_loaded` = 1.
- **Multi-word with gaps:** 3 words 00B00313, 00500393, 00300413, with `s_valid` dropped randomly → writes at addresses 0x0, 0x4, 0x8 in order; `s_ready` = 0 during each WRITE cycle; a held byte is consumed once only.
- **Partial word:** 6 bytes with `s_last` on byte 6 → one write only, at addr 0; `err` = 1, `done` = 0, `cpu_rst_n` stays 0, `s_ready` = 0.
- **Overflow** (DEPTH=4): 16 bytes, no `s_last` → 4 writes at 0x0–0xC, then `err` = 1; a 17th byte is never accepted.
- **Reset mid-load:** after 6 bytes, pulse `rst` for one cycle, then stream word DEADBEEF with last → write at addr 0 with `mem_wdata` = DEADBEEF; `words_loaded` = 1.
- **Sticky DONE:** after DONE, keep `s_valid` = 1 for 10 cycles → no `mem_we`; `s_ready` = 0, `done` = 1, and `cpu_rst_n` = 1 throughout.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package riscv_pkg;

    typedef enum logic [1:0] {
        LOAD,
        WRITE,
        DONE,
        ERR
    } loader_state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);
    localparam logic [31:0] IMEM_BASE      = 32'h0;

endpackage

// File: rtl/imem_word_packer.sv
// Packs a byte stream little-endian into a 32-bit word; full flags the last free lane.
module imem_word_packer
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        clear,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        full
);

    logic [31:0]       word_q;
    logic [LANE_W-1:0] lane_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word_q <= '0;
            lane_q <= '0;
        end else if (push) begin
            word_q[8*lane_q +: 8] <= data;
            lane_q                <= lane_q + LANE_W'(1);
        end
    end

    assign word = word_q;
    assign full = (lane_q == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams a byte image into instruction memory, holding the CPU in reset until the
// last word lands; overflow or a truncated final word aborts the load.
module imem_loader
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             cpu_rst_n,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] words_loaded
);

    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    loader_state_t     state_q;
    logic [ADDR_W-1:0] word_addr_q;
    logic [CNT_W-1:0]  words_q;
    logic              last_q;
    logic              s_ready_q;
    logic              mem_we_q;
    logic              done_q;
    logic              err_q;
    logic              cpu_run_q;

    logic              accept;
    logic [31:0]       pack_word;
    logic              pack_full;

    assign accept = s_valid && s_ready_q;

    imem_word_packer u_packer (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .clear (state_q == WRITE),
        .data  (s_data),
        .word  (pack_word),
        .full  (pack_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            word_addr_q <= '0;
            words_q     <= '0;
            last_q      <= 1'b0;
            s_ready_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_run_q   <= 1'b0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (accept) begin
                        if (pack_full) begin
                            state_q   <= WRITE;
                            last_q    <= s_last;
                            s_ready_q <= 1'b0;
                            mem_we_q  <= 1'b1;
                        end else if (s_last) begin
                            state_q   <= ERR;
                            s_ready_q <= 1'b0;
                            err_q     <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    mem_we_q <= 1'b0;
                    words_q  <= words_q + CNT_W'(1);
                    // Address saturates at the top word so it can never wrap.
                    if (word_addr_q != LAST_ADDR) begin
                        word_addr_q <= word_addr_q + ADDR_W'(1);
                    end
                    if (last_q) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        cpu_run_q <= 1'b1;
                    end else if (word_addr_q == LAST_ADDR) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end else begin
                        state_q   <= LOAD;
                        s_ready_q <= 1'b1;
                    end
                end
                DONE: begin
                end
                ERR: begin
                end
            endcase
        end
    end

    assign s_ready      = s_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = IMEM_BASE | (32'(word_addr_q) << 2);
    assign mem_wdata    = pack_word;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;
    // CPU goes back into reset in the very cycle the loader reset is sampled.
    assign cpu_rst_n    = cpu_run_q && !rst;

endmodule
